row_loader_fp16: RTL
====================

# row_loader_fp16

- Upstream feeder for the fp16 row accumulator in the softmax/SFU path.
- Collects a row of fp16 elements from a valid/ready stream into a register array of `data_cnt` entries, then releases the accumulator from reset so it sums the row.
- Latches the accumulator's result when it reports done, and re-arms for the next row.
- Optionally tracks the row maximum for the softmax max-subtraction stage.

## Interface
Parameters:
- data_width, 16, element width (fp16 encoding).
- data_cnt, 64, elements per row; must be ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  input element valid.
- in_ready  out  1  loader accepts an element this cycle.
- in_data  in  data_width  fp16 element.
- in_last  in  1  final element of a short row; sampled only on an accepted beat.
- array  out  data_width × data_cnt  unpacked row buffer; drives the accumulator's array input.
- acc_rst_n  out  1  active-low reset to the accumulator.
- acc_done  in  1  accumulator done.
- acc_result  in  data_width  accumulator result.
- sum_out  out  data_width  latched row sum.
- max_out  out  data_width  latched row maximum; 0 when MAX_TRACK_EN is undefined.
- sum_valid  out  1  one-cycle pulse: sum_out/max_out updated.
- count  out  $clog2(data_cnt+1)  elements written in the current row.

## Operation
Reset values:
- state=FILL; array entries=0; count=0.
- acc_rst_n=0; sum_out=0; max_out=0; sum_valid=0.
- running max=16'hFC00 (−inf).

FILL:
- in_ready=1, decoded combinationally from state.
- Accepted beat (in_valid && in_ready): array[count] <= in_data; count <= count+1.
- Exit to RUN on the same edge, with acc_rst_n <= 1, when the accepted beat has count==data_cnt−1 or in_last=1.
- Entries not written keep 0. fp16 +0 leaves the sum unchanged.

RUN:
- in_ready=0; array is frozen; count holds.
- When acc_done=1 is sampled:
  - sum_out <= acc_result; max_out <= running max; sum_valid <= 1.
  - acc_rst_n <= 0; all array entries <= 0; count <= 0; running max <= 16'hFC00.
  - state <= FILL.

Boundary behaviour:
- in_valid held while in_ready=0: no write; in_data is ignored.
- in_last on the beat that fills the buffer: identical to a full row.
- in_last when in_valid=0: ignored.
- acc_done=1 while in FILL: ignored. It cannot occur legally, because the accumulator is held in reset.
- rst_n asserted mid-row: all state returns to reset values immediately; the partial row is discarded and no sum_valid is produced.
- The loader does not check acc_result for NaN/Inf; the value is passed through unchanged.

## Timing
- in_ready is high in every FILL cycle, including the cycle sum_valid is high. Back-to-back rows are therefore possible with no bubble.
- Last beat accepted at edge T: in_ready=0 and acc_rst_n=1 from T onward.
- acc_done first seen high at edge D: sum_valid=1 for exactly the cycle after D; acc_rst_n=0 and in_ready=1 from D.
- acc_rst_n is glitch-free (direct flop output); deassertion is synchronous to clk.
- Row throughput is (elements accepted) + accumulator latency + 1 cycles.

## Configuration
Macro: MAX_TRACK_EN.

Defined:
- On every accepted beat, update the running max when in_data orders greater than it.
- Ordering key: a sign-set value maps to ~x; a sign-clear value maps to x | 16'h8000; compare keys unsigned.
- NaN inputs (exponent all ones, mantissa ≠ 0) never update the max.
- −0 and +0 compare as distinct keys; +0 wins.
- Zero entries that were never written (short row) do not participate.

Undefined:
- No compare logic; max_out is tied to 0.

## Test plan
Bench uses data_cnt=4 and an accumulator model that asserts acc_done 12 cycles after acc_rst_n rises, returning 16'h4500.

1. Reset, then stream 3C00, 4000, 4200, 4400 with in_valid held high:
   - array = {4400, 4200, 4000, 3C00}; in_ready drops on the 4th accept edge; acc_rst_n rises on the same edge.
   - sum_valid pulses once with sum_out=4500; with MAX_TRACK_EN, max_out=4400.
2. Short row 3C00, 4000 with in_last on the 2nd beat:
   - count=2; array[2]=array[3]=0; RUN entered on that edge.
   - With MAX_TRACK_EN, max_out=4000.
3. in_valid high with in_data=5555 during RUN:
   - No array write; count stays 4.
4. Two rows back-to-back:
   - In the sum_valid cycle, in_ready=1 and a beat is accepted into array[0].
   - Array cleared except that new entry.
5. rst_n pulsed low after 2 beats:
   - array=0, count=0, acc_rst_n=0, in_ready=1 asynchronously; no sum_valid.
6. MAX_TRACK_EN with row BC00, 7E01 (NaN), C000, FC00:
   - max_out=BC00.

Source files
------------

// File: rtl/row_loader_fp16.sv
// rtl/row_loader_fp16.sv - fp16 row collector and accumulator sequencer
//
// Collects one row of fp16 elements from a valid/ready stream into a register
// array. It then releases the downstream row accumulator from reset and
// latches the accumulator's result when it reports done.
//
// Optional feature macro: MAX_TRACK_EN
//   When defined, the loader also tracks the row maximum and reports it on
//   max_out.
//   When undefined, max_out is tied to 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready stream handshake for incoming elements
//   in_data, in_last  element payload; in_last ends a short row
//   array             row buffer, drives the accumulator's array input
//   acc_rst_n         active-low reset to the accumulator (flop output)
//   acc_done          accumulator done
//   acc_result        accumulator result
//   sum_out, max_out  latched row sum / row maximum
//   sum_valid         one-cycle pulse when sum_out/max_out update
//   count             elements written in the current row
module row_loader_fp16 #(
  parameter int data_width = 16,
  parameter int data_cnt   = 64,
  localparam int cw        = $clog2(data_cnt + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_last,
  output logic [data_width-1:0] array [data_cnt],
  output logic                  acc_rst_n,
  input  logic                  acc_done,
  input  logic [data_width-1:0] acc_result,
  output logic [data_width-1:0] sum_out,
  output logic [data_width-1:0] max_out,
  output logic                  sum_valid,
  output logic [cw-1:0]         count
);

  typedef enum logic {FILL, RUN} state_t;

  state_t                state_q, state_d;
  logic [data_width-1:0] array_q [data_cnt];
  logic [data_width-1:0] array_d [data_cnt];
  logic [cw-1:0]         count_q, count_d;
  logic                  acc_rst_n_q, acc_rst_n_d;
  logic [data_width-1:0] sum_q, sum_d;
  logic                  sum_valid_q, sum_valid_d;

`ifdef MAX_TRACK_EN
  localparam logic [data_width-1:0] neg_inf = data_width'(16'hFC00);

  logic [data_width-1:0] run_max_q, run_max_d;
  logic [data_width-1:0] max_q, max_d;
  logic                  in_is_nan;

  // Maps fp16 onto an unsigned total order: negatives are bit-inverted so the
  // larger magnitude sorts lower, and positives get the top bit forced so
  // they sort above every negative. As a result, -0 and +0 stay distinct.
  function automatic logic [data_width-1:0] ord_key(input logic [data_width-1:0] x);
    ord_key = x[data_width-1] ? ~x : (x | {1'b1, {(data_width-1){1'b0}}});
  endfunction

  assign in_is_nan = (in_data[14:10] == 5'h1f) && (in_data[9:0] != 10'd0);
`endif

  logic accept;

  assign in_ready = (state_q == FILL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    array_d     = array_q;
    count_d     = count_q;
    acc_rst_n_d = acc_rst_n_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
`ifdef MAX_TRACK_EN
    run_max_d   = run_max_q;
    max_d       = max_q;
`endif
    case (state_q)
      FILL: begin
        if (accept) begin
          // Compare per entry rather than indexing, so a wider count never
          // addresses past the buffer.
          for (int i = 0; i < data_cnt; i++) begin
            if (count_q == cw'(i)) array_d[i] = in_data;
          end
          count_d = count_q + cw'(1);
`ifdef MAX_TRACK_EN
          if (!in_is_nan && (ord_key(in_data) > ord_key(run_max_q))) run_max_d = in_data;
`endif
          if ((count_q == cw'(data_cnt - 1)) || in_last) begin
            state_d     = RUN;
            acc_rst_n_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (acc_done) begin
          sum_d       = acc_result;
          sum_valid_d = 1'b1;
          acc_rst_n_d = 1'b0;
          count_d     = '0;
          for (int i = 0; i < data_cnt; i++) array_d[i] = '0;
`ifdef MAX_TRACK_EN
          max_d       = run_max_q;
          run_max_d   = neg_inf;
`endif
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      for (int i = 0; i < data_cnt; i++) array_q[i] <= '0;
      count_q     <= '0;
      acc_rst_n_q <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
`ifdef MAX_TRACK_EN
      run_max_q   <= neg_inf;
      max_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      array_q     <= array_d;
      count_q     <= count_d;
      acc_rst_n_q <= acc_rst_n_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
`ifdef MAX_TRACK_EN
      run_max_q   <= run_max_d;
      max_q       <= max_d;
`endif
    end
  end

  assign array     = array_q;
  assign count     = count_q;
  assign acc_rst_n = acc_rst_n_q;
  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;
`ifdef MAX_TRACK_EN
  assign max_out   = max_q;
`else
  assign max_out   = '0;
`endif

endmodule
